// File: rtl/vta_enq_rr_arbiter.sv
// rtl/vta_enq_rr_arbiter.sv - packet-locked round-robin arbiter for a shared queue enqueue port
module vta_enq_rr_arbiter #(
    parameter  int NUM_REQ   = 4,
    parameter  int DATA_W    = 128,
    parameter  int MAX_BURST = 16,
    localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        io_in_valid,
    output logic [NUM_REQ-1:0]        io_in_ready,
    input  logic [NUM_REQ*DATA_W-1:0] io_in_bits,
    input  logic [NUM_REQ-1:0]        io_in_last,
    output logic                      io_out_valid,
    input  logic                      io_out_ready,
    output logic [DATA_W-1:0]         io_out_bits,
    output logic [IDX_W-1:0]          io_chosen,
    output logic                      io_busy
);

    localparam int              CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state, state_next;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_next;
    logic [IDX_W-1:0]   grant, grant_next;
    logic [CNT_W-1:0]   beat_cnt, beat_cnt_next;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   cand;
    logic               found;
    logic               xfer;
    logic               end_burst;
    logic [DATA_W-1:0]  lane [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign lane[g] = io_in_bits[g*DATA_W +: DATA_W];
    end

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        winner = rr_ptr;
        cand   = rr_ptr;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && io_in_valid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign xfer      = (state == BURST) && io_in_valid[grant] && io_out_ready;
    assign end_burst = io_in_last[grant] || (beat_cnt == CNT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant    <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            rr_ptr   <= rr_ptr_next;
            grant    <= grant_next;
            beat_cnt <= beat_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        rr_ptr_next   = rr_ptr;
        grant_next    = grant;
        beat_cnt_next = beat_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next    = BURST;
                    grant_next    = winner;
                    rr_ptr_next   = IDX_W'((int'(winner) + 1) % NUM_REQ);
                    beat_cnt_next = '0;
                end
            end
            BURST: begin
                // Forced release at MAX_BURST ignores last; the rest re-arbitrates.
                if (xfer) begin
                    if (end_burst) begin
                        state_next    = IDLE;
                        beat_cnt_next = '0;
                    end else begin
                        beat_cnt_next = beat_cnt + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        io_out_valid = 1'b0;
        io_in_ready  = '0;
        io_out_bits  = lane[grant];
        if (state == BURST) begin
            io_out_valid       = io_in_valid[grant];
            io_in_ready[grant] = io_out_ready;
        end
    end

    assign io_busy   = (state == BURST);
    assign io_chosen = grant;

endmodule

// File: tb/tb_vta_enq_rr_arbiter.sv
// tb/tb_vta_enq_rr_arbiter.sv - scoreboard bench for vta_enq_rr_arbiter
module tb_vta_enq_rr_arbiter;

    localparam int NR = 4;
    localparam int DW = 128;

    typedef struct packed { logic last; logic [DW-1:0] data; } beat_t;
    typedef struct packed { logic [1:0] src; logic [DW-1:0] data; } exp_t;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [NR-1:0]    io_in_valid = '0;
    logic [NR-1:0]    io_in_ready;
    logic [NR*DW-1:0] io_in_bits = '0;
    logic [NR-1:0]    io_in_last = '0;
    logic             io_out_valid;
    logic             io_out_ready = 1'b1;
    logic [DW-1:0]    io_out_bits;
    logic [1:0]       io_chosen;
    logic             io_busy;

    beat_t     req_q [NR][$];
    exp_t      sb[$];
    logic      ready_cfg = 1'b1;
    logic [NR-1:0] mask = '0;
    logic      xfer = 1'b0;
    int        errors = 0;
    int        checks = 0;

    vta_enq_rr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(4)) dut (
        .clock(clock), .reset(reset),
        .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
        .io_in_bits(io_in_bits), .io_in_last(io_in_last),
        .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
        .io_out_bits(io_out_bits), .io_chosen(io_chosen), .io_busy(io_busy)
    );

    always #5 clock = ~clock;

    task automatic push_pkt(input int r, input int n, input logic [DW-1:0] base, input bit with_last);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.data = base + DW'(k);
            b.last = with_last && (k == n - 1);
            req_q[r].push_back(b);
        end
    endtask

    task automatic sb_add(input int src, input logic [DW-1:0] base, input int from, input int n);
        exp_t e;
        for (int k = from; k < from + n; k++) begin
            e.src  = 2'(src);
            e.data = base + DW'(k);
            sb.push_back(e);
        end
    endtask

    // One cycle: present requester heads at negedge, record the handshake that the next posedge takes.
    task automatic tick();
        exp_t e;
        @(negedge clock);
        io_out_ready = ready_cfg;
        for (int i = 0; i < NR; i++) begin
            if (req_q[i].size() > 0) begin
                io_in_bits[9'(i*DW) +: DW] = req_q[i][0].data;
                io_in_last[2'(i)]          = req_q[i][0].last;
                io_in_valid[2'(i)]         = !mask[2'(i)];
            end else begin
                io_in_bits[9'(i*DW) +: DW] = '0;
                io_in_last[2'(i)]          = 1'b0;
                io_in_valid[2'(i)]         = 1'b0;
            end
        end
        #1;
        xfer = io_out_valid && io_out_ready;
        if (xfer) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got src=%0d data=%h, required no beat", io_chosen, io_out_bits);
            end else begin
                e = sb.pop_front();
                if (io_out_bits !== e.data || io_chosen !== e.src) begin
                    errors++;
                    $display("FAIL beat_order: got src=%0d data=%h, required src=%0d data=%h",
                             io_chosen, io_out_bits, e.src, e.data);
                end
            end
        end
        for (int i = 0; i < NR; i++)
            if (io_in_valid[2'(i)] && io_in_ready[2'(i)]) req_q[i].delete(0);
        #1;
    endtask

    task automatic drain(input int budget, output bit ok);
        for (int c = 0; c < budget && sb.size() > 0; c++) tick();
        ok = (sb.size() == 0);
    endtask

    task automatic do_reset();
        @(posedge clock); #1 reset = 1'b1;
        tick();
        @(posedge clock); #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        bit ok;
        push_pkt(1, 1, 128'h77, 1'b1);
        sb_add(1, 128'h77, 0, 1);
        tick(); tick();
        checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", io_out_valid); end
        checks++; if (io_in_ready !== 4'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0000", io_in_ready); end
        checks++; if (io_chosen !== 2'd0) begin errors++; $display("FAIL reset_chosen: got %0d required 0", io_chosen); end
        checks++; if (io_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", io_busy); end
        @(posedge clock); #1 reset = 1'b0;
        drain(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL reset_drain: got %0d pending beats required 0", sb.size()); end
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        push_pkt(2, 3, 128'hA, 1'b1);
        sb_add(2, 128'hA, 0, 3);
        tick();
        checks++; if (io_out_valid !== 1'b0 || io_busy !== 1'b0) begin errors++; $display("FAIL single_arb_cycle: got valid=%b busy=%b required 0 0", io_out_valid, io_busy); end
        tick();
        checks++; if (io_out_valid !== 1'b1 || io_chosen !== 2'd2) begin errors++; $display("FAIL single_first_beat: got valid=%b chosen=%0d required 1 2", io_out_valid, io_chosen); end
        drain(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_drain: got %0d pending required 0", sb.size()); end
        tick();
        checks++; if (io_busy !== 1'b0) begin errors++; $display("FAIL single_idle: got busy=%b required 0", io_busy); end
        push_pkt(1, 1, 128'h11, 1'b1);
        push_pkt(3, 1, 128'h33, 1'b1);
        sb_add(3, 128'h33, 0, 1);
        sb_add(1, 128'h11, 0, 1);
        drain(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_rr_ptr: got %0d pending required 0", sb.size()); end
    endtask

    task automatic test_all_four();
        bit ok;
        do_reset();
        push_pkt(0, 1, 128'h1000, 1'b1);
        push_pkt(0, 1, 128'h1001, 1'b1);
        push_pkt(1, 1, 128'h1100, 1'b1);
        push_pkt(2, 1, 128'h1200, 1'b1);
        push_pkt(3, 1, 128'h1300, 1'b1);
        sb_add(0, 128'h1000, 0, 1); sb_add(1, 128'h1100, 0, 1);
        sb_add(2, 128'h1200, 0, 1); sb_add(3, 128'h1300, 0, 1);
        sb_add(0, 128'h1001, 0, 1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++; if ($countones(io_in_ready) > 1) begin errors++; $display("FAIL all4_onehot: got in_ready=%b required at most one bit", io_in_ready); end
            checks++; if (xfer !== (k % 2 == 0)) begin errors++; $display("FAIL all4_cadence: cycle %0d got xfer=%b required %b", k, xfer, (k % 2 == 0)); end
        end
        drain(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL all4_drain: got %0d pending required 0", sb.size()); end
    endtask

    task automatic test_backpressure();
        bit ok;
        push_pkt(1, 5, 128'h100, 1'b1);
        push_pkt(2, 1, 128'h200, 1'b1);
        sb_add(1, 128'h100, 0, 4); sb_add(2, 128'h200, 0, 1); sb_add(1, 128'h100, 4, 1);
        tick(); tick(); tick();
        ready_cfg = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (io_in_ready !== 4'b0) begin errors++; $display("FAIL bp_in_ready: got %b required 0000", io_in_ready); end
            checks++; if (io_out_valid !== 1'b1 || io_out_bits !== 128'h102) begin errors++; $display("FAIL bp_stable: got valid=%b bits=%h required 1 102", io_out_valid, io_out_bits); end
        end
        ready_cfg = 1'b1;
        drain(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_drain: got %0d pending required 0", sb.size()); end
    endtask

    task automatic test_forced_release();
        bit ok;
        push_pkt(0, 6, 128'h300, 1'b1);
        push_pkt(1, 1, 128'h400, 1'b1);
        sb_add(0, 128'h300, 0, 4); sb_add(1, 128'h400, 0, 1); sb_add(0, 128'h300, 4, 2);
        drain(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL forced_drain: got %0d pending required 0", sb.size()); end
    endtask

    task automatic test_drop_valid();
        bit ok;
        push_pkt(1, 3, 128'h500, 1'b1);
        push_pkt(3, 1, 128'h600, 1'b1);
        sb_add(1, 128'h500, 0, 3); sb_add(3, 128'h600, 0, 1);
        tick(); tick();
        mask[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (io_out_valid !== 1'b0 || io_in_ready[3] !== 1'b0) begin errors++; $display("FAIL drop_gap: got valid=%b ready3=%b required 0 0", io_out_valid, io_in_ready[3]); end
            checks++; if (io_busy !== 1'b1 || io_chosen !== 2'd1) begin errors++; $display("FAIL drop_hold: got busy=%b chosen=%0d required 1 1", io_busy, io_chosen); end
        end
        mask[1] = 1'b0;
        drain(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL drop_drain: got %0d pending required 0", sb.size()); end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        do_reset();
        push_pkt(0, 5, 128'h700, 1'b1);
        push_pkt(3, 1, 128'h800, 1'b1);
        sb_add(0, 128'h700, 0, 5); sb_add(3, 128'h800, 0, 1);
        tick(); tick(); tick();
        @(posedge clock); #1 reset = 1'b1;
        #1;
        checks++; if (io_in_ready !== 4'b0 || io_out_valid !== 1'b0) begin errors++; $display("FAIL midreset_async: got ready=%b valid=%b required 0000 0", io_in_ready, io_out_valid); end
        checks++; if (io_busy !== 1'b0 || io_chosen !== 2'd0) begin errors++; $display("FAIL midreset_state: got busy=%b chosen=%0d required 0 0", io_busy, io_chosen); end
        tick();
        @(posedge clock); #1 reset = 1'b0;
        drain(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midreset_drain: got %0d pending required 0", sb.size()); end
        for (int k = 0; k < 4; k++) tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_backpressure();
        test_forced_release();
        test_drop_valid();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
